// File: rtl/nvme_sync_fifo_if.sv
// Bus bundle for nvme_sync_fifo: write/read requests, read data, occupancy and error flags.
// The master modport is the producer/consumer side; the slave modport is the FIFO itself.
interface nvme_sync_fifo_if #(
    parameter int DATA_WIDTH = 771,
    parameter int DEPTH      = 16
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] data;
    logic                  wrreq;
    logic                  rdreq;
    logic [DATA_WIDTH-1:0] q;
    logic                  rdempty;
    logic                  wrfull;
    logic [ADDR_W:0]       usedw;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data, wrreq, rdreq,
        input  q, rdempty, wrfull, usedw, almost_full, overflow, underflow
    );

    modport slave (
        input  data, wrreq, rdreq,
        output q, rdempty, wrfull, usedw, almost_full, overflow, underflow
    );
endinterface

// File: rtl/nvme_sync_fifo.sv
// Single-clock FIFO for NVMe command/completion words with occupancy count, almost-full and sticky error flags.
// Optional show-ahead read is enabled by defining NVME_FIFO_SHOWAHEAD_EN.
module nvme_sync_fifo #(
    parameter int DATA_WIDTH = 771,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    nvme_sync_fifo_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_LVL   = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       usedw_q, usedw_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  empty, full, wr_en, rd_en;

    // Status flags come only from the registered count, so requests never reach them combinationally.
    assign empty = (usedw_q == '0);
    assign full  = (usedw_q == FULL_LVL);
    assign wr_en = bus.wrreq && !full;
    assign rd_en = bus.rdreq && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        usedw_d     = usedw_q;
        overflow_d  = overflow_q  | (bus.wrreq & full);
        underflow_d = underflow_q | (bus.rdreq & empty);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_en, rd_en})
            2'b10:   usedw_d = usedw_q + CNT_ONE;
            2'b01:   usedw_d = usedw_q - CNT_ONE;
            default: usedw_d = usedw_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usedw_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            usedw_q     <= usedw_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.data;
        end
    end

`ifdef NVME_FIFO_SHOWAHEAD_EN
    assign bus.q = mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (rd_en) begin
            q_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q = q_q;
`endif

    assign bus.rdempty     = empty;
    assign bus.wrfull      = full;
    assign bus.usedw       = usedw_q;
    assign bus.almost_full = (usedw_q >= AF_LVL);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_nvme_sync_fifo.sv
// Directed self-checking bench for nvme_sync_fifo at DEPTH=4, AF_THRESH=3, DATA_WIDTH=8.
// Read-data checks adapt to show-ahead timing when NVME_FIFO_SHOWAHEAD_EN is defined.
module tb_nvme_sync_fifo;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AF = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    nvme_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    nvme_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(AF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then let the edge pass and settle before anything is sampled.
    task automatic applyStimulus(input logic rstn, input logic wr, input logic rd, input logic [DW-1:0] d);
        rst_n     = rstn;
        bus.wrreq = wr;
        bus.rdreq = rd;
        bus.data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read (optionally with a concurrent write) and check the word that read returns.
    task automatic xfer(input string tag, input logic wr, input logic [DW-1:0] d, input logic [DW-1:0] exp);
`ifdef NVME_FIFO_SHOWAHEAD_EN
        checkOutput(tag, 16'(bus.q), 16'(exp));
        applyStimulus(1'b1, wr, 1'b1, d);
`else
        applyStimulus(1'b1, wr, 1'b1, d);
        checkOutput(tag, 16'(bus.q), 16'(exp));
`endif
    endtask

    initial begin
        bus.data  = '0;
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rst_rdempty", 16'(bus.rdempty), 16'd1);
        checkOutput("rst_wrfull", 16'(bus.wrfull), 16'd0);
        checkOutput("rst_usedw", 16'(bus.usedw), 16'd0);
        checkOutput("rst_af", 16'(bus.almost_full), 16'd0);
        checkOutput("rst_ovf", 16'(bus.overflow), 16'd0);
        checkOutput("rst_unf", 16'(bus.underflow), 16'd0);
`ifndef NVME_FIFO_SHOWAHEAD_EN
        checkOutput("rst_q", 16'(bus.q), 16'd0);
`endif

        // Fill to full, then overfill
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hA0);
        checkOutput("w0_usedw", 16'(bus.usedw), 16'd1);
        checkOutput("w0_rdempty", 16'(bus.rdempty), 16'd0);
        checkOutput("w0_af", 16'(bus.almost_full), 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hA1);
        checkOutput("w1_af", 16'(bus.almost_full), 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hA2);
        checkOutput("w2_af", 16'(bus.almost_full), 16'd1);
        checkOutput("w2_wrfull", 16'(bus.wrfull), 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hA3);
        checkOutput("w3_wrfull", 16'(bus.wrfull), 16'd1);
        checkOutput("w3_usedw", 16'(bus.usedw), 16'd4);
        checkOutput("w3_ovf", 16'(bus.overflow), 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF);
        checkOutput("ovf_usedw", 16'(bus.usedw), 16'd4);
        checkOutput("ovf_flag", 16'(bus.overflow), 16'd1);

        // Drain in order, then underflow
        bus.wrreq = 1'b0;
        xfer("rd_a0", 1'b0, 8'h00, 8'hA0);
        xfer("rd_a1", 1'b0, 8'h00, 8'hA1);
        checkOutput("rd_a1_usedw", 16'(bus.usedw), 16'd2);
        xfer("rd_a2", 1'b0, 8'h00, 8'hA2);
        xfer("rd_a3", 1'b0, 8'h00, 8'hA3);
        checkOutput("drain_rdempty", 16'(bus.rdempty), 16'd1);
        checkOutput("drain_unf", 16'(bus.underflow), 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("unf_flag", 16'(bus.underflow), 16'd1);
        checkOutput("unf_usedw", 16'(bus.usedw), 16'd0);
`ifndef NVME_FIFO_SHOWAHEAD_EN
        checkOutput("unf_q_hold", 16'(bus.q), 16'hA3);
`endif

        // Steady-state streaming across pointer wrap
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h30);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h31);
        checkOutput("pre_usedw", 16'(bus.usedw), 16'd2);
        for (int i = 0; i < 10; i++) begin
            xfer($sformatf("stream_q%0d", i), 1'b1, 8'(8'h10 + i),
                 (i < 2) ? 8'(8'h30 + i) : 8'(8'h10 + i - 2));
            checkOutput($sformatf("stream_usedw%0d", i), 16'(bus.usedw), 16'd2);
        end
        xfer("stream_tail0", 1'b0, 8'h00, 8'h18);
        xfer("stream_tail1", 1'b0, 8'h00, 8'h19);
        checkOutput("stream_rdempty", 16'(bus.rdempty), 16'd1);

        // Reset mid-operation clears sticky flags; then simultaneous read/write while full
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rst2_ovf", 16'(bus.overflow), 16'd0);
        checkOutput("rst2_unf", 16'(bus.underflow), 16'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
        end
        checkOutput("full2_wrfull", 16'(bus.wrfull), 16'd1);
        xfer("full_rw_q", 1'b1, 8'h99, 8'h40);
        checkOutput("full_rw_usedw", 16'(bus.usedw), 16'd3);
        checkOutput("full_rw_ovf", 16'(bus.overflow), 16'd1);
        checkOutput("full_rw_wrfull", 16'(bus.wrfull), 16'd0);

        // Reset with entries stored discards them; no stale data afterwards
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rst3_usedw", 16'(bus.usedw), 16'd0);
        checkOutput("rst3_rdempty", 16'(bus.rdempty), 16'd1);
        checkOutput("rst3_ovf", 16'(bus.overflow), 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
        checkOutput("w5a_usedw", 16'(bus.usedw), 16'd1);
        xfer("rd_5a", 1'b0, 8'h00, 8'h5A);
        checkOutput("rd_5a_rdempty", 16'(bus.rdempty), 16'd1);

        // The write dropped while full must not appear in the data stream
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'h60 + i));
        end
        xfer("drop_q0", 1'b1, 8'h99, 8'h60);
        xfer("drop_q1", 1'b0, 8'h00, 8'h61);
        xfer("drop_q2", 1'b0, 8'h00, 8'h62);
        xfer("drop_q3", 1'b0, 8'h00, 8'h63);
        checkOutput("drop_rdempty", 16'(bus.rdempty), 16'd1);
        checkOutput("drop_unf", 16'(bus.underflow), 16'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
